multi_button_sync: RTL and testbench

MULTI_BUTTON_SYNC -- requirements
Module: multi_button_sync

---
 rtl/multi_button_sync_pkg.sv | 17 +
 rtl/button_sync_channel.sv | 150 +++++++++++++++
 rtl/multi_button_sync.sv | 44 ++++
 tb/tb_multi_button_sync.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/multi_button_sync_pkg.sv
// Shared types and default parameter values for the multi-channel button synchronizer.
package multi_button_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_PEND = 2'd1,
    ST_HELD       = 2'd2,
    ST_REL_PEND   = 2'd3
  } btn_state_e;

  localparam int DEF_N_CH            = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 1000;
  localparam int DEF_REPEAT_PERIOD   = 250;

endpackage

// File: rtl/button_sync_channel.sv
// One button channel: input synchronizer, debounce FSM and registered press/release pulses.
// Auto-repeat while held is built only when MULTI_BUTTON_SYNC_REPEAT_EN is defined.
module button_sync_channel
  import multi_button_sync_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef MULTI_BUTTON_SYNC_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bi,
  output logic bo,
  output logic br,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  btn_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   bo_q, bo_d, br_q, br_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bi};
  end

  assign synced  = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

`ifdef MULTI_BUTTON_SYNC_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_q, rpt_d, rpt_last;
  logic          rep_q, rep_d;  // first repeat already issued in this hold

  assign rpt_last = rep_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      rep_q <= rep_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bo_q    <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bo_q    <= bo_d;
      br_q    <= br_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bo_d    = 1'b0;
    br_d    = 1'b0;
`ifdef MULTI_BUTTON_SYNC_REPEAT_EN
    rpt_d   = rpt_q;
    rep_d   = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (synced) begin
          state_d = ST_PRESS_PEND;
          cnt_d   = '0;
        end
      end
      ST_PRESS_PEND: begin
        if (!synced) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          bo_d    = 1'b1;
`ifdef MULTI_BUTTON_SYNC_REPEAT_EN
          rpt_d   = '0;
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!synced) begin
          state_d = ST_REL_PEND;
          cnt_d   = '0;
`ifdef MULTI_BUTTON_SYNC_REPEAT_EN
          rpt_d   = '0;
          rep_d   = 1'b0;
`endif
        end
`ifdef MULTI_BUTTON_SYNC_REPEAT_EN
        else if (rpt_q == rpt_last) begin
          bo_d  = 1'b1;
          rpt_d = '0;
          rep_d = 1'b1;
        end else begin
          rpt_d = rpt_q + RW'(1);
        end
`endif
      end
      ST_REL_PEND: begin
        if (synced) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          br_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bo    = bo_q;
  assign br    = br_q;
  assign level = (state_q == ST_HELD) || (state_q == ST_REL_PEND);

endmodule

// File: rtl/multi_button_sync.sv
// N_CH independent debounced button channels with press/release pulses and levels.
// Auto-repeat is enabled by defining MULTI_BUTTON_SYNC_REPEAT_EN.
module multi_button_sync
  import multi_button_sync_pkg::*;
#(
  parameter int N_CH            = DEF_N_CH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [N_CH-1:0] Bi,
  output logic [N_CH-1:0] Bo,
  output logic [N_CH-1:0] Br,
  output logic [N_CH-1:0] Level
);

  if (N_CH < 1 || N_CH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("multi_button_sync: parameter out of range");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_sync_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef MULTI_BUTTON_SYNC_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_channel (
      .clk   (Clk),
      .rst_n (Rst_n),
      .bi    (Bi[i]),
      .bo    (Bo[i]),
      .br    (Br[i]),
      .level (Level[i])
    );
  end

endmodule

// File: tb/tb_multi_button_sync.sv
// Directed self-checking bench for multi_button_sync (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_multi_button_sync;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [3:0] Bi;
  logic [3:0] Bo, Br, Level;

  multi_button_sync #(
    .N_CH            (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Bi    (Bi),
    .Bo    (Bo),
    .Br    (Br),
    .Level (Level)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] bi_seq [64];
  logic [3:0] bo_log [64];
  logic [3:0] br_log [64];
  logic [3:0] lv_log [64];
  logic [3:0] overlap = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic fill(input int lo, input int hi, input logic [3:0] v);
    for (int j = lo; j <= hi; j++) bi_seq[j] = v;
  endtask

  // bi_seq[j] is held across rising edge j; log[j] is the cycle after edge j.
  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      Bi = bi_seq[j];
      @(negedge Clk);
      bo_log[j] = Bo;
      br_log[j] = Br;
      lv_log[j] = Level;
      overlap   = overlap | (Bo & Br);
    end
  endtask

  function automatic logic [63:0] bits(input int sel, input int ch, input int lo, input int hi);
    logic [63:0] r = '0;
    for (int j = lo; j <= hi; j++)
      r[j] = (sel == 0) ? bo_log[j][ch] : (sel == 1) ? br_log[j][ch] : lv_log[j][ch];
    return r;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] r = '0;
    for (int j = lo; j <= hi; j++) r[j] = 1'b1;
    return r;
  endfunction

  localparam logic [63:0] BIT6  = 64'd1 << 6;
  localparam logic [63:0] BIT14 = 64'd1 << 14;

  logic [63:0] exp_rep;

  initial begin
    Rst_n = 1'b0;
    Bi    = '0;
    #1;
    check("reset_outputs", 64'({Bo, Br, Level}), 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Single press on channel 0.
    fill(0, 19, 4'b0001);
    run(20);
    check("t1_bo0", bits(0, 0, 0, 15), BIT6);
    check("t1_level0", bits(2, 0, 0, 19), span(6, 19));
    check("t1_br0", bits(1, 0, 0, 19), 64'd0);
    check("t1_bo_other", bits(0, 1, 0, 19) | bits(0, 2, 0, 19) | bits(0, 3, 0, 19), 64'd0);
    check("t1_br_other", bits(1, 1, 0, 19) | bits(1, 2, 0, 19) | bits(1, 3, 0, 19), 64'd0);

    // Channel 1 bounces, final rise at index 8.
    fill(0, 1, 4'b0011); fill(2, 3, 4'b0001);
    fill(4, 5, 4'b0011); fill(6, 7, 4'b0001);
    fill(8, 23, 4'b0011);
    run(24);
    check("t2_bo1", bits(0, 1, 0, 23), BIT14);
    check("t2_level1", bits(2, 1, 0, 23), span(14, 23));

    // Short 3-cycle glitch on channel 2.
    fill(0, 2, 4'b0111); fill(3, 15, 4'b0011);
    run(16);
    check("t3_pulses2", bits(0, 2, 0, 15) | bits(1, 2, 0, 15), 64'd0);
    check("t3_level2", bits(2, 2, 0, 15), 64'd0);

    // Release channel 0.
    fill(0, 11, 4'b0010);
    run(12);
    check("t4_br0", bits(1, 0, 0, 11), BIT6);
    check("t4_level0", bits(2, 0, 0, 11), span(0, 5));
    check("t4_bo0_after_release", bits(0, 0, 2, 11), 64'd0);

    // Channels 0 and 3 pressed on the same edge.
    fill(0, 11, 4'b1011);
    run(12);
    check("t4_simul_bo", 64'(bo_log[6]), 64'(4'b1001));
    check("t4_simul_bo0", bits(0, 0, 0, 11), BIT6);
    check("t4_simul_bo3", bits(0, 3, 0, 11), BIT6);
    check("t4_simul_level", 64'(lv_log[11]), 64'(4'b1011));

    // Reset two cycles into channel 2 press-pending, with 0/1/3 held.
    fill(0, 3, 4'b1111);
    run(4);
    check("t5_no_early_bo2", bits(0, 2, 0, 3), 64'd0);
    Rst_n = 1'b0;
    #1;
    check("t5_async_reset", 64'({Bo, Br, Level}), 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    fill(0, 15, 4'b1111);
    run(16);
    check("t5_bo_all", 64'(bo_log[6]), 64'(4'b1111));
    for (int c = 0; c < 4; c++)
      check($sformatf("t5_single_bo%0d", c), bits(0, c, 0, 15), BIT6);
    check("t5_level_before", 64'(lv_log[5]), 64'd0);
    check("t5_level_after", 64'(lv_log[6]), 64'(4'b1111));

    // Release everything together.
    fill(0, 11, 4'b0000);
    run(12);
    check("t6_br_all", 64'(br_log[6]), 64'(4'b1111));
    check("t6_no_bo", bits(0, 0, 2, 11) | bits(0, 1, 2, 11) | bits(0, 2, 2, 11) | bits(0, 3, 2, 11), 64'd0);
    check("t6_level_idle", 64'(lv_log[11]), 64'd0);

    // Long hold on channel 0, then release.
    exp_rep = BIT6;
`ifdef MULTI_BUTTON_SYNC_REPEAT_EN
    for (int j = 16; j < 40; j += 5) exp_rep[j] = 1'b1;
`endif
    fill(0, 39, 4'b0001);
    run(40);
    check("t7_hold_bo0", bits(0, 0, 0, 39), exp_rep);
    fill(0, 19, 4'b0000);
    run(20);
    check("t7_release_br0", bits(1, 0, 0, 19), BIT6);
    check("t7_release_no_bo0", bits(0, 0, 2, 19), 64'd0);

    check("bo_br_overlap", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
